// File: rtl/memory_issue_sequencer.sv
// memory_issue_sequencer
//   Buffers memory-class instructions from the decoder and issues them to the
//   `memory` block one at a time. It inserts the spacing that `memory` cannot
//   enforce itself: BRAM read latency after WRITEB, a write slot after SENDL,
//   and a wait for fresh write-buffer data before LOADB. Issue stops on END
//   until reset.
//
// Ports
//   clk_in                 rising-edge clock
//   rst_in                 asynchronous active-low reset
//   instr_in               instruction from decoder (opcode in bits [0:3])
//   instr_valid_in         instr_in valid this cycle
//   instr_ready_out        FIFO can accept (registered)
//   write_buffer_valid_in  FMA write buffer holds fresh results
//   instr_out              instruction issued to `memory` (holds last value)
//   instr_valid_out        one-cycle pulse per issued instruction
//   busy_out               FIFO non-empty or FSM not in ISSUE (registered)
//   halted_out             an END has been issued
//
// state    | meaning
// ---------+----------------------------------------------------------
// ISSUE    | decode FIFO head, issue / pop / branch on opcode
// WAIT_BUF | LOADB at head, waiting for write_buffer_valid_in
// WAIT_RD  | counting down BRAM read latency after WRITEB
// GAP      | one idle cycle after SENDL for the BRAM write slot
// HALTED   | END issued; nothing more until reset

module memory_issue_sequencer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter int BRAM_LATENCY      = 3
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [0:INSTRUCTION_WIDTH-1] instr_in,
  input  logic                         instr_valid_in,
  output logic                         instr_ready_out,
  input  logic                         write_buffer_valid_in,
  output logic [0:INSTRUCTION_WIDTH-1] instr_out,
  output logic                         instr_valid_out,
  output logic                         busy_out,
  output logic                         halted_out
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (BRAM_LATENCY > 0) ? $clog2(BRAM_LATENCY + 1) : 1;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_END    = 4'b0001;
  localparam logic [3:0] OP_SENDL  = 4'b1000;
  localparam logic [3:0] OP_LOADB  = 4'b1001;
  localparam logic [3:0] OP_WRITEB = 4'b1010;

  typedef enum logic [2:0] {
    S_ISSUE,
    S_WAIT_BUF,
    S_WAIT_RD,
    S_GAP,
    S_HALTED
  } state_t;

  state_t                       state_q, state_d;
  logic [WAIT_W-1:0]            wait_q, wait_d;
  logic [0:INSTRUCTION_WIDTH-1] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         push_q;
  logic                         ready_q;
  logic                         busy_q;
  logic [0:INSTRUCTION_WIDTH-1] instr_out_q;
  logic                         valid_out_q;

  logic                         push;
  logic                         pop;
  logic                         issue;
  logic                         head_avail;
  logic [0:INSTRUCTION_WIDTH-1] head;
  logic [3:0]                   head_op;

  assign push    = instr_valid_in && ready_q;
  assign head    = mem_q[rd_ptr_q];
  assign head_op = head[0:3];

  // An entry written on the previous edge is not yet eligible for decode;
  // this gives the two-edge push-to-issue latency. Only the newest entry can
  // be that fresh, so the head is eligible unless it is the sole entry and
  // it arrived last edge.
  assign head_avail = (count_q != '0) && !(push_q && (count_q == CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        if (head_avail) begin
          unique case (head_op)
            OP_NOP: begin
              pop = 1'b1;
            end
            OP_LOADB: begin
              if (write_buffer_valid_in) begin
                pop   = 1'b1;
                issue = 1'b1;
              end else begin
                state_d = S_WAIT_BUF;
              end
            end
            OP_WRITEB: begin
              pop   = 1'b1;
              issue = 1'b1;
              if (BRAM_LATENCY > 0) begin
                wait_d  = WAIT_W'(BRAM_LATENCY);
                state_d = S_WAIT_RD;
              end
            end
            OP_SENDL: begin
              pop     = 1'b1;
              issue   = 1'b1;
              state_d = S_GAP;
            end
            OP_END: begin
              pop     = 1'b1;
              issue   = 1'b1;
              state_d = S_HALTED;
            end
            default: begin
              pop   = 1'b1;
              issue = 1'b1;
            end
          endcase
        end
      end
      S_WAIT_BUF: begin
        if (write_buffer_valid_in) begin
          pop     = 1'b1;
          issue   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_WAIT_RD: begin
        // Terminal count at 1 so the counter lands on 0 as ISSUE resumes;
        // the next issue then follows WRITEB by exactly BRAM_LATENCY+1.
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) begin
          wait_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_GAP: begin
        state_d = S_ISSUE;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_ISSUE;
      wait_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      push_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      instr_out_q <= '0;
      valid_out_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      push_q  <= push;
      if (push) begin
        mem_q[wr_ptr_q] <= instr_in;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      ready_q     <= (count_d != CNT_W'(FIFO_DEPTH)) && (state_d != S_HALTED);
      busy_q      <= (count_d != '0) || (state_d != S_ISSUE);
      valid_out_q <= issue;
      if (issue) begin
        instr_out_q <= head;
      end
    end
  end

  assign instr_ready_out = ready_q;
  assign instr_out       = instr_out_q;
  assign instr_valid_out = valid_out_q;
  assign busy_out        = busy_q;
  assign halted_out      = (state_q == S_HALTED);

endmodule

// File: doc/memory_issue_sequencer.md
Name: memory_issue_sequencer

Overview:
- Sits between the instruction decoder and the `memory` block.
- Buffers memory-class instructions in a small FIFO and issues them to `memory` one at a time.
- Enforces the timing rules `memory` cannot enforce itself:
  - BRAM read latency after WRITEB.
  - The BRAM write slot after SENDL.
  - Write-buffer availability before LOADB.
- Halts issue on END until reset.

Parameters:
- INSTRUCTION_WIDTH, 32: bits per instruction. Opcode is bits [0:3], MSB-first indexing as in the ISA.
- FIFO_DEPTH, 4: instruction FIFO entries. Must be a power of two, at least 2.
- BRAM_LATENCY, 3: idle cycles inserted after issuing WRITEB. Matches the HIGH_PERFORMANCE BRAM plus the output handshake.

Ports:
- clk_in, input, 1: single clock; all logic is on the rising edge.
- rst_in, input, 1: asynchronous, active-low reset.
- instr_in, input, [0:INSTRUCTION_WIDTH-1]: instruction from the decoder.
- instr_valid_in, input, 1: instr_in is valid this cycle.
- instr_ready_out, output, 1: the FIFO can accept an instruction this cycle.
- write_buffer_valid_in, input, 1: the FMA write buffer holds fresh results. Same signal that feeds `memory`.
- instr_out, output, [0:INSTRUCTION_WIDTH-1]: instruction issued to `memory`.
- instr_valid_out, output, 1: one-cycle pulse per issued instruction.
- busy_out, output, 1: FIFO is non-empty or the FSM is not in ISSUE.
- halted_out, output, 1: an END has been issued.

Behaviour:

Reset:
- Asserting rst_in low clears all state immediately, including mid-wait.
- Reset values:
  - FIFO empty.
  - instr_out = 0, instr_valid_out = 0.
  - instr_ready_out = 0 while reset is held, 1 from the first edge after deassertion.
  - busy_out = 0, halted_out = 0.
  - FSM = ISSUE, wait counter = 0.
- Instructions in flight at reset are discarded.

Input handshake:
- A push happens when instr_valid_in && instr_ready_out.
- instr_ready_out = !full && !halted. It is registered and has no combinational dependence on instr_valid_in.
- A push when the FIFO is full is impossible by construction.
- A simultaneous push and pop in the same cycle is legal and leaves occupancy unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. A separate count of width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.

FSM states: ISSUE, WAIT_BUF, WAIT_RD, GAP, HALTED.

ISSUE, with the FIFO non-empty, decodes the head opcode:
- NOP (0000): pop without issuing; instr_valid_out stays 0.
- LOADB (1001):
  - If write_buffer_valid_in = 1: pop and issue.
  - Otherwise: go to WAIT_BUF without popping.
- WRITEB (1010): pop and issue, load the counter with BRAM_LATENCY, go to WAIT_RD.
- SENDL (1000): pop and issue, go to GAP.
- END (0001): pop and issue, go to HALTED.
- Any other opcode (SMA, LOADI, LOAD, etc.): pop and issue, stay in ISSUE. At most one instruction is issued per cycle.

Other states:
- WAIT_BUF: on the first cycle write_buffer_valid_in = 1, pop and issue the LOADB, then return to ISSUE.
- WAIT_RD: decrement the counter each cycle. When it reaches 0, return to ISSUE. Nothing is issued while waiting, so after WRITEB at cycle t the next issue is no earlier than t+BRAM_LATENCY+1.
- GAP: one cycle with no issue, then ISSUE.
- HALTED: no issue and instr_ready_out = 0. The FIFO contents are retained but never issued. Only reset exits this state.

Issue timing:
- Issuing registers the FIFO head into instr_out and sets instr_valid_out = 1 for exactly one cycle.
- instr_out holds its last value afterwards.
- Latency from push (edge k) into an empty FIFO in ISSUE to instr_valid_out high is 2 cycles: high after edge k+2.

Status outputs:
- busy_out is registered: (count != 0) || (state != ISSUE).
- halted_out = (state == HALTED).

Test Plan:
- Reset mid-operation: push SMA(0x0005) and LOADI, assert rst_in=0 for 1 cycle → instr_valid_out never pulses, instr_ready_out=1 and busy_out=0 after release.
- Basic ordering: push SMA 0x60000500, then LOADI 0x7003C000 → two consecutive instr_valid_out pulses two cycles after each push, instr_out matching bit-exact, in order.
- WRITEB spacing: push WRITEB 0xA1000701 then SMA → SMA pulse exactly BRAM_LATENCY+1 = 4 cycles after the WRITEB pulse.
- LOADB stall: write_buffer_valid_in=0, push LOADB 0x91000023 → no issue for 10 cycles and busy_out=1; raise valid → LOADB issued 1 cycle later.
- Full/backpressure with NOP: hold instr_valid_in high with 6 SMAs while a LOADB stalls at the head → instr_ready_out drops after 4 entries, no loss or duplication, all issued in order once valid rises; separately, a NOP at the head is popped with no pulse.
- END: push END, then SMA → END issued, halted_out=1, instr_ready_out=0, SMA never issued until reset.
